// File: rtl/mem_loader.sv
// Framed byte-stream boot loader: parses SYNC/addr/len/payload/csum frames from the
// host byte source and writes the payload into main memory while holding the CPU off.
//
// state  | meaning
// IDLE   | bus released to CPU, discarding bytes until SYNC_BYTE
// ADDR_H | capturing start address high byte
// ADDR_L | capturing start address low byte
// LEN_H  | capturing payload length high byte
// LEN_L  | capturing payload length low byte
// DATA   | waiting for next payload byte
// WRITE  | single-cycle memory load strobe for the latched byte
// CSUM   | waiting for checksum byte
// FIN    | one-cycle done pulse, then back to IDLE
module mem_loader #(
   parameter int                WIDTH_ADDR = 16,
   parameter int                WIDTH      = 8,
   parameter logic [WIDTH-1:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [WIDTH-1:0]      rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [WIDTH_ADDR-1:0] addr_out,
   output logic [WIDTH-1:0]      data_out,
   output logic                  load_n,
   output logic                  bus_dir,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err
);

   localparam int LEN_W = 2 * WIDTH;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_LEN_H,
      S_LEN_L,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_FIN
   } state_t;

   state_t                  state_q, state_d;
   logic [WIDTH_ADDR-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]        len_q, len_d;
   logic [WIDTH-1:0]        sum_q, sum_d;
   logic [WIDTH-1:0]        data_q, data_d;
   logic                    err_q, err_d;

   logic                    ready_s;
   logic                    write_s;
   logic [LEN_W-1:0]        len_next;
   logic [WIDTH-1:0]        csum_chk;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      sum_d    = sum_q;
      data_d   = data_q;
      err_d    = err_q;
      ready_s  = 1'b0;
      write_s  = 1'b0;
      len_next = {len_q[WIDTH-1:0], rx_data};
      csum_chk = sum_q + rx_data;

      case (state_q)
         S_IDLE: begin
            ready_s = 1'b1;
            if (rx_valid && rx_data == SYNC_BYTE) begin
               state_d = S_ADDR_H;
               err_d   = 1'b0;
               sum_d   = '0;
            end
         end
         S_ADDR_H: begin
            ready_s = 1'b1;
            if (rx_valid) begin
               addr_d  = {addr_q[WIDTH_ADDR-WIDTH-1:0], rx_data};
               state_d = S_ADDR_L;
            end
         end
         S_ADDR_L: begin
            ready_s = 1'b1;
            if (rx_valid) begin
               addr_d  = {addr_q[WIDTH_ADDR-WIDTH-1:0], rx_data};
               state_d = S_LEN_H;
            end
         end
         S_LEN_H: begin
            ready_s = 1'b1;
            if (rx_valid) begin
               len_d   = len_next;
               state_d = S_LEN_L;
            end
         end
         S_LEN_L: begin
            ready_s = 1'b1;
            if (rx_valid) begin
               len_d   = len_next;
               state_d = (len_next == '0) ? S_CSUM : S_DATA;
            end
         end
         S_DATA: begin
            ready_s = 1'b1;
            if (rx_valid) begin
               data_d  = rx_data;
               sum_d   = csum_chk;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // address wraps naturally at the top of the address space
            write_s = 1'b1;
            addr_d  = addr_q + WIDTH_ADDR'(1);
            len_d   = len_q - LEN_W'(1);
            state_d = (len_q == LEN_W'(1)) ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            ready_s = 1'b1;
            if (rx_valid) begin
               err_d   = (csum_chk != '0);
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Gating with reset_n keeps the strobes quiet during reset even mid-frame.
   assign rx_ready = ready_s & reset_n;
   assign load_n   = ~(write_s & reset_n);
   assign bus_dir  = ~(write_s & reset_n);
   assign cpu_hold = (state_q != S_IDLE) & reset_n;
   assign done     = (state_q == S_FIN) & reset_n;
   assign err      = err_q;
   assign addr_out = addr_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected memory writes are queued as payload bytes
// are driven and popped when the load strobe is seen.
module tb_mem_loader;

   logic        clk;
   logic        reset_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [15:0] addr_out;
   logic [7:0]  data_out;
   logic        load_n;
   logic        bus_dir;
   logic        cpu_hold;
   logic        done;
   logic        err;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   int         n_checks;
   int         n_errors;
   int         n_writes;
   logic [7:0] pay [8];

   mem_loader #(.WIDTH_ADDR(16), .WIDTH(8), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .addr_out (addr_out),
      .data_out (data_out),
      .load_n   (load_n),
      .bus_dir  (bus_dir),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && !load_n) begin
         n_writes++;
         chk("wr_ready_low", {31'd0, rx_ready}, 32'd0);
         chk("wr_bus_dir", {31'd0, bus_dir}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", exp_q.size(), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", {16'd0, addr_out}, {16'd0, mon_e.a});
            chk("wr_data", {24'd0, data_out}, {24'd0, mon_e.d});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input logic exp_err, input int w0, input int len);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("done", {31'd0, done}, 32'd1);
      chk("err", {31'd0, err}, {31'd0, exp_err});
      chk("write_count", n_writes - w0, len);
      @(negedge clk);
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("cpu_hold_after", {31'd0, cpu_hold}, 32'd0);
      chk("sb_empty", exp_q.size(), 32'd0);
   endtask

   task automatic send_frame(input logic [15:0] a, input int len, input logic [7:0] cs,
                             input bit hold);
      logic [7:0] s;
      logic       exp_err;
      int         w0;
      w0 = n_writes;
      s  = 8'h00;
      send_byte(8'hA5);
      chk("cpu_hold_in_frame", {31'd0, cpu_hold}, 32'd1);
      chk("err_cleared_by_sync", {31'd0, err}, 32'd0);
      if (!hold) rx_valid = 1'b0;
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back('{a: a + 16'(i), d: pay[i]});
         s = s + pay[i];
         send_byte(pay[i]);
         if (!hold) rx_valid = 1'b0;
      end
      send_byte(cs);
      rx_valid = 1'b0;
      exp_err = ((s + cs) != 8'h00);
      wait_done(exp_err, w0, len);
   endtask

   initial begin
      int w0;
      n_checks = 0;
      n_errors = 0;
      n_writes = 0;
      reset_n  = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_addr", {16'd0, addr_out}, 32'd0);
      chk("rst_data", {24'd0, data_out}, 32'd0);
      chk("rst_load_n", {31'd0, load_n}, 32'd1);
      chk("rst_bus_dir", {31'd0, bus_dir}, 32'd1);
      chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

      // basic frame with a correct checksum
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
      send_frame(16'h1234, 3, 8'h9A, 1'b0);

      // same payload, wrong checksum -> sticky err
      send_frame(16'h1234, 3, 8'h00, 1'b0);

      // address rollover; first A5 also clears the stale err
      pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
      send_frame(16'hFFFE, 3, 8'hFA, 1'b0);

      // garbage ahead of a zero-length frame
      send_byte(8'h00);
      chk("garbage_idle", {31'd0, cpu_hold}, 32'd0);
      send_byte(8'hFF);
      chk("garbage_idle", {31'd0, cpu_hold}, 32'd0);
      rx_valid = 1'b0;
      send_frame(16'h4000, 0, 8'h00, 1'b0);

      // rx_valid held high throughout, back-pressure during WRITE
      pay[0] = 8'hAA; pay[1] = 8'h55;
      send_frame(16'h0010, 2, 8'h01, 1'b1);

      // reset mid-frame after the first data byte has been written
      w0 = n_writes;
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h04);
      exp_q.push_back('{a: 16'h0020, d: 8'h77});
      send_byte(8'h77);
      rx_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("mid_rst_addr", {16'd0, addr_out}, 32'd0);
      chk("mid_rst_data", {24'd0, data_out}, 32'd0);
      chk("mid_rst_load_n", {31'd0, load_n}, 32'd1);
      chk("mid_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_rst_writes", n_writes - w0, 32'd1);
      chk("mid_rst_sb_empty", exp_q.size(), 32'd0);

      // complete frame afterwards, with SYNC value inside the payload
      pay[0] = 8'h5A; pay[1] = 8'hA5;
      send_frame(16'h0030, 2, 8'h01, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
